dct_idct_seq_ctrl: RTL and testbench
====================================

// Module: dct_idct_seq_ctrl
// PURPOSE
//  Frame-level sequencer for the dct -> idct chain. Streams a frame of samples into dct
//  under its start/reading handshake and captures 64 idct results per done burst.
//  Drives the idct rapx precision select from a programmable cycle window.
//  Detects end-of-frame, with a drain timeout. Replaces hand-written testbench sequencing.
// PARAMETERS
//  BitWidth      31     MSB index of sample buses (bus width BitWidth+1 = 32)
//  NUM_SAMPLES   65536  samples per frame; must be a multiple of 64
//  DRAIN_TMO     16384  max cycles in DRAIN before forced DONE
//  APX_DEFAULT   1      rapx value outside the approximation window
// PORTS
//  clk          in   1   clock, all logic on posedge
//  reset        in   1   synchronous, active-high; also drives dct reset and idct racc
//  go           in   1   start a frame; sampled only in IDLE
//  apx_lo       in   32  window start, cycle count since go (exclusive)
//  apx_hi       in   32  window end, cycle count since go (exclusive)
//  src_valid    in   1   upstream sample valid
//  src_data     in   32  upstream sample
//  src_ready    out  1   sample accepted this cycle (src_valid && src_ready)
//  dct_start    out  1   to dct start
//  dct_din      out  32  to dct din
//  dct_reading  in   1   dct is accepting samples
//  dct_done     in   1   dct output burst active (counted only)
//  idct_done    in   1   idct output burst active
//  idct_dout    in   32  idct result
//  rapx         out  1   to idct rapx
//  pix_valid    out  1   pix_data valid
//  pix_data     out  9   idct_dout[25:17]
//  busy         out  1   state != IDLE
//  frame_done   out  1   one-cycle pulse on entry to DONE
//  timeout      out  1   sticky; set when DRAIN exits on DRAIN_TMO; cleared on go
//  underrun     out  1   sticky; set when dct_reading && !src_valid in FEED; cleared on go
//  blk_out      out  16  idct blocks captured this frame
// BEHAVIOUR
//  Reset values: all outputs 0 except rapx=APX_DEFAULT; state=IDLE; all counters 0.
//  FSM states: IDLE -> FEED -> DRAIN -> DONE -> IDLE.
//   IDLE: go=1 -> FEED. Same edge clears timeout, underrun, blk_out, in_cnt, cyc_cnt.
//   FEED: dct_start=1. src_ready = dct_reading && (in_cnt < NUM_SAMPLES).
//    On each accept, dct_din <= src_data (registered, 1-cycle latency) and in_cnt++.
//    If dct_reading && !src_valid: dct_din <= 0, underrun <= 1, in_cnt unchanged.
//    in_cnt == NUM_SAMPLES && !dct_reading -> DRAIN; dct_start deasserts on the same edge.
//   DRAIN: tmo_cnt++ each cycle.
//    blk_out == NUM_SAMPLES/64 -> DONE.
//    Otherwise, tmo_cnt == DRAIN_TMO-1 -> DONE with timeout <= 1.
//   DONE: frame_done=1 for exactly one cycle -> IDLE.
//  Capture runs in FEED and DRAIN only:
//   - While idct_done=1 and out_cnt<64: pix_valid=1, pix_data=idct_dout[25:17]
//     (registered, 1-cycle latency), out_cnt++.
//   - out_cnt==63 accept: blk_out++.
//   - idct_done=0: out_cnt <= 0.
//   - Bursts longer than 64 cycles: samples beyond the 64th are dropped.
//  rapx:
//   - cyc_cnt increments every cycle while busy; saturates at 2^32-1.
//   - rapx <= (apx_lo < cyc_cnt < apx_hi) ? ~APX_DEFAULT : APX_DEFAULT. Registered.
//   - apx_hi <= apx_lo gives an empty window: rapx stays at APX_DEFAULT.
//  Boundaries:
//   - go while busy is ignored.
//   - reset mid-frame returns to IDLE next edge; dct_start, pix_valid and frame_done drop that edge.
//   - idct_done rising and DRAIN exit on the same edge: the sample is captured before exit.
//   - NUM_SAMPLES reached while dct_reading is still 1: src_ready=0 and FSM holds in FEED.
// STRUCTURE
//  Package dct_seq_pkg:
//   - state enum (IDLE, FEED, DRAIN, DONE)
//   - BLK_SAMPLES=64
//   - PIX_MSB=25, PIX_LSB=17
//  Sub-module dct_seq_apx_win: cycle counter plus window compare producing rapx.
//  FSM, feed path and capture path stay in the top module.
// TESTING
//  1. reset 3 cycles; check outputs -> all 0, rapx=APX_DEFAULT, busy=0.
//  2. NUM_SAMPLES=128, dct model reads 64 at a time, 2 idct bursts of 64 -> 128 accepts,
//     128 pix_valid, blk_out=2, one frame_done, timeout=0.
//  3. src_valid low 3 cycles mid-read -> underrun=1, dct_din=0 those cycles, in_cnt still reaches 128.
//  4. idct model emits only 1 burst, DRAIN_TMO=16 -> DONE 16 cycles after DRAIN entry,
//     timeout=1, blk_out=1.
//  5. apx_lo=10, apx_hi=20, APX_DEFAULT=1 -> rapx=0 exactly for cyc_cnt 11..19 (+1 register cycle);
//     apx_lo=20, apx_hi=10 -> rapx constant 1.
//  6. reset asserted in FEED at in_cnt=40 -> next edge IDLE, dct_start=0;
//     re-go completes a clean frame, blk_out=2.

Source files
------------

// File: rtl/dct_seq_pkg.sv
// dct_seq_pkg: shared state encoding and constants for the dct/idct frame sequencer.
package dct_seq_pkg;
    typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_e;
    localparam int BLK_SAMPLES = 64;
    localparam int PIX_MSB     = 25;
    localparam int PIX_LSB     = 17;
endpackage

// File: rtl/dct_seq_apx_win.sv
// dct_seq_apx_win: saturating cycle counter since go, and registered rapx window compare.
module dct_seq_apx_win #(
    parameter bit APX_DEFAULT = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        busy,
    input  logic [31:0] apx_lo,
    input  logic [31:0] apx_hi,
    output logic        rapx
);
    logic [31:0] cyc_cnt_q, cyc_cnt_d;
    logic        rapx_q, rapx_d;

    always_comb begin
        cyc_cnt_d = clr ? '0 : (busy && cyc_cnt_q != '1) ? cyc_cnt_q + 32'd1 : cyc_cnt_q;
        rapx_d    = (apx_lo < cyc_cnt_q && cyc_cnt_q < apx_hi) ? ~APX_DEFAULT : APX_DEFAULT;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_cnt_q <= '0;
            rapx_q    <= APX_DEFAULT;
        end else begin
            cyc_cnt_q <= cyc_cnt_d;
            rapx_q    <= rapx_d;
        end
    end

    assign rapx = rapx_q;
endmodule

// File: rtl/dct_idct_seq_ctrl.sv
// dct_idct_seq_ctrl: streams a frame into dct, captures idct bursts of 64,
// and ends the frame on block count or drain timeout.
module dct_idct_seq_ctrl
    import dct_seq_pkg::*;
#(
    parameter int BitWidth    = 31,
    parameter int NUM_SAMPLES = 65536,
    parameter int DRAIN_TMO   = 16384,
    parameter bit APX_DEFAULT = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                go,
    input  logic [31:0]         apx_lo,
    input  logic [31:0]         apx_hi,
    input  logic                src_valid,
    input  logic [BitWidth:0]   src_data,
    output logic                src_ready,
    output logic                dct_start,
    output logic [BitWidth:0]   dct_din,
    input  logic                dct_reading,
    input  logic                dct_done,
    input  logic                idct_done,
    input  logic [BitWidth:0]   idct_dout,
    output logic                rapx,
    output logic                pix_valid,
    output logic [8:0]          pix_data,
    output logic                busy,
    output logic                frame_done,
    output logic                timeout,
    output logic                underrun,
    output logic [15:0]         blk_out
);
    localparam logic [31:0] NS       = 32'(NUM_SAMPLES);
    localparam logic [15:0] NBLK     = 16'(NUM_SAMPLES / BLK_SAMPLES);
    localparam logic [31:0] TMO_LAST = 32'(DRAIN_TMO - 1);
    localparam logic [6:0]  BLK_N    = 7'(BLK_SAMPLES);
    localparam logic [6:0]  BLK_LAST = 7'(BLK_SAMPLES - 1);

    state_e              state_q, state_d;
    logic [31:0]         in_cnt_q, in_cnt_d;
    logic [31:0]         tmo_cnt_q, tmo_cnt_d;
    logic [6:0]          out_cnt_q, out_cnt_d;
    logic [15:0]         blk_out_q, blk_out_d;
    logic [BitWidth:0]   dct_din_q, dct_din_d;
    logic [8:0]          pix_data_q, pix_data_d;
    logic                pix_valid_q, pix_valid_d;
    logic                timeout_q, timeout_d;
    logic                underrun_q, underrun_d;
    logic                go_start, accept, starving, cap, drain_tmo;
    logic                unused_bits;

    assign go_start  = state_q == IDLE && go;
    assign src_ready = state_q == FEED && dct_reading && in_cnt_q < NS;
    assign accept    = src_ready && src_valid;
    // underrun only counts cycles where a sample was actually wanted
    assign starving  = src_ready && !src_valid;
    assign cap       = (state_q == FEED || state_q == DRAIN) && idct_done && out_cnt_q < BLK_N;
    assign drain_tmo = state_q == DRAIN && blk_out_q != NBLK && tmo_cnt_q == TMO_LAST;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (go) state_d = FEED;
            FEED:    if (in_cnt_q == NS && !dct_reading) state_d = DRAIN;
            DRAIN:   if (blk_out_q == NBLK || tmo_cnt_q == TMO_LAST) state_d = DONE;
            default: state_d = IDLE;
        endcase
        in_cnt_d    = go_start ? '0 : accept ? in_cnt_q + 32'd1 : in_cnt_q;
        tmo_cnt_d   = state_q == DRAIN ? tmo_cnt_q + 32'd1 : '0;
        dct_din_d   = accept ? src_data : starving ? '0 : dct_din_q;
        underrun_d  = go_start ? 1'b0 : underrun_q | starving;
        timeout_d   = go_start ? 1'b0 : timeout_q | drain_tmo;
        out_cnt_d   = !idct_done ? '0 : cap ? out_cnt_q + 7'd1 : out_cnt_q;
        blk_out_d   = go_start ? '0 : (cap && out_cnt_q == BLK_LAST) ? blk_out_q + 16'd1 : blk_out_q;
        pix_valid_d = cap;
        pix_data_d  = cap ? idct_dout[PIX_MSB:PIX_LSB] : pix_data_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            in_cnt_q    <= '0;
            tmo_cnt_q   <= '0;
            out_cnt_q   <= '0;
            blk_out_q   <= '0;
            dct_din_q   <= '0;
            pix_data_q  <= '0;
            pix_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_cnt_q    <= in_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            out_cnt_q   <= out_cnt_d;
            blk_out_q   <= blk_out_d;
            dct_din_q   <= dct_din_d;
            pix_data_q  <= pix_data_d;
            pix_valid_q <= pix_valid_d;
            timeout_q   <= timeout_d;
            underrun_q  <= underrun_d;
        end
    end

    dct_seq_apx_win #(.APX_DEFAULT(APX_DEFAULT)) u_apx (
        .clk    (clk),
        .reset  (reset),
        .clr    (go_start),
        .busy   (busy),
        .apx_lo (apx_lo),
        .apx_hi (apx_hi),
        .rapx   (rapx)
    );

    assign busy        = state_q != IDLE;
    assign dct_start   = state_q == FEED;
    assign frame_done  = state_q == DONE;
    assign dct_din     = dct_din_q;
    assign pix_valid   = pix_valid_q;
    assign pix_data    = pix_data_q;
    assign timeout     = timeout_q;
    assign underrun    = underrun_q;
    assign blk_out     = blk_out_q;
    assign unused_bits = ^{idct_dout[BitWidth:PIX_MSB+1], idct_dout[PIX_LSB-1:0], dct_done};
endmodule

// File: tb/tb_dct_idct_seq_ctrl.sv
// tb_dct_idct_seq_ctrl: frame-level vectors against small dct/idct behavioural models.
module tb_dct_idct_seq_ctrl;
    localparam int NS = 128;
    localparam int DT = 16;
    localparam int S_FEED = 1;
    localparam int S_DRAIN = 2;

    typedef struct {
        int gap_at;
        int nb;
        int blen;
        int hold_rd;
        int go_mid;
        int lo;
        int hi;
        int exp_tmo;
        int exp_ur;
        int exp_blk;
        int exp_pix;
    } frame_t;

    logic        clk, reset, go, src_valid, src_ready, dct_start, dct_reading, dct_done;
    logic        idct_done, rapx, pix_valid, busy, frame_done, timeout, underrun;
    logic [31:0] apx_lo, apx_hi, src_data, dct_din, idct_dout;
    logic [8:0]  pix_data;
    logic [15:0] blk_out;
    int          tests, fails;
    frame_t      tbl[4];

    dct_idct_seq_ctrl #(.BitWidth(31), .NUM_SAMPLES(NS), .DRAIN_TMO(DT), .APX_DEFAULT(1'b1)) dut (
        .clk(clk), .reset(reset), .go(go), .apx_lo(apx_lo), .apx_hi(apx_hi),
        .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
        .dct_start(dct_start), .dct_din(dct_din), .dct_reading(dct_reading), .dct_done(dct_done),
        .idct_done(idct_done), .idct_dout(idct_dout), .rapx(rapx), .pix_valid(pix_valid),
        .pix_data(pix_data), .busy(busy), .frame_done(frame_done), .timeout(timeout),
        .underrun(underrun), .blk_out(blk_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic run_frame(input frame_t f);
        int acc, caps, bstarted, bpos, hold, gap_left, rd_gap, e, drain_edge, full_edge, done_edge;
        int exp_done, npix, nacc, km1, st;
        bit gapped, acc_p, cap_p, ur_exp, din_known, rd, exp_rdy;
        logic [31:0] din_exp;
        logic [8:0]  pd_exp;
        acc = 0; caps = 0; bstarted = 0; bpos = -1; hold = f.hold_rd; gap_left = 0; rd_gap = 0;
        drain_edge = -1; full_edge = -1; done_edge = -1; npix = 0; nacc = 0;
        gapped = 0; ur_exp = 0; din_known = 0; din_exp = '0; pd_exp = '0;
        apx_lo = f.lo; apx_hi = f.hi;
        go = 1'b1; idct_done = 1'b0; dct_reading = 1'b0; src_valid = 1'b0;
        @(posedge clk); e = 0; #1;
        st = S_FEED;
        chk("go_busy", busy, 1);
        chk("go_clr_underrun", underrun, 0);
        chk("go_clr_timeout", timeout, 0);
        chk("go_clr_blk", blk_out, 0);
        for (int it = 0; it < 400 && done_edge < 0; it++) begin
            rd = (acc < NS) ? (rd_gap == 0) : (hold > 0);
            if (f.gap_at >= 0 && !gapped && rd && acc == f.gap_at) begin
                gapped = 1; gap_left = 3;
            end
            go = (f.go_mid != 0) && acc < 100;
            dct_reading = rd;
            src_valid = gap_left == 0;
            src_data = {16'ha5c3, 16'(acc)};
            if (bpos < 0 && !idct_done && bstarted < f.nb && acc >= 8 + 64 * bstarted) begin
                bpos = 0; bstarted++;
            end
            idct_done = bpos >= 0;
            idct_dout = {6'h15, 9'(bstarted * 37 + bpos * 5), 17'h0b00d};
            #1;
            exp_rdy = st == S_FEED && rd && acc < NS;
            chk("src_ready", src_ready, exp_rdy);
            chk("dct_start", dct_start, st == S_FEED);
            if (src_ready && src_valid) nacc++;
            acc_p = exp_rdy && src_valid;
            if (exp_rdy) begin
                din_exp = src_valid ? src_data : 32'd0;
                din_known = 1;
                if (!src_valid) ur_exp = 1;
            end
            cap_p = idct_done && bpos >= 0 && bpos < 64 && (st == S_FEED || st == S_DRAIN);
            if (cap_p) pd_exp = idct_dout[25:17];
            if (st == S_FEED && acc == NS && !rd) drain_edge = e + 1;
            @(posedge clk); e++; #1;
            if (drain_edge == e) st = S_DRAIN;
            if (rd_gap > 0) rd_gap--;
            if (acc >= NS && hold > 0) hold--;
            if (gap_left > 0) gap_left--;
            if (acc_p) begin
                acc++;
                if (acc % 64 == 0 && acc < NS) rd_gap = 4;
            end
            if (cap_p) begin
                caps++;
                if (caps == 64 * f.nb) full_edge = e;
            end
            if (bpos >= 0) begin
                bpos++;
                if (bpos == f.blen) bpos = -1;
            end
            if (pix_valid) npix++;
            chk("pix_valid", pix_valid, cap_p);
            if (cap_p) chk("pix_data", pix_data, pd_exp);
            if (din_known) chk("dct_din", dct_din, din_exp);
            chk("underrun", underrun, ur_exp);
            km1 = e - 1;
            chk("rapx", rapx, (f.lo < km1 && km1 < f.hi) ? 0 : 1);
            if (frame_done) done_edge = e;
        end
        exp_done = (f.nb == NS / 64) ? ((drain_edge > full_edge ? drain_edge : full_edge) + 1)
                                      : drain_edge + DT;
        chk("done_edge", done_edge, exp_done);
        chk("accepts", nacc, NS);
        chk("pix_count", npix, f.exp_pix);
        chk("blk_out", blk_out, f.exp_blk);
        chk("timeout", timeout, f.exp_tmo);
        go = 1'b0; dct_reading = 1'b0; src_valid = 1'b0;
        @(posedge clk); #1;
        chk("post_busy", busy, 0);
        chk("post_frame_done", frame_done, 0);
        chk("post_underrun", underrun, f.exp_ur);
        chk("post_blk_out", blk_out, f.exp_blk);
        idct_done = 1'b0;
    endtask

    initial begin
        tests = 0; fails = 0;
        //         gap nb blen hold gomid lo  hi  tmo ur blk pix
        tbl[0] = '{-1, 2, 64,  0,   0,    0,  0,  0,  0, 2,  128};
        tbl[1] = '{40, 2, 66,  0,   0,    10, 20, 0,  1, 2,  128};
        tbl[2] = '{-1, 1, 64,  0,   0,    0,  0,  1,  0, 1,  64};
        tbl[3] = '{-1, 2, 64,  3,   1,    20, 10, 0,  0, 2,  128};
        reset = 1'b1; go = 1'b0; apx_lo = '0; apx_hi = '0; src_valid = 1'b0; src_data = '0;
        dct_reading = 1'b0; dct_done = 1'b0; idct_done = 1'b0; idct_dout = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_src_ready", src_ready, 0);
        chk("rst_dct_start", dct_start, 0);
        chk("rst_dct_din", dct_din, 0);
        chk("rst_rapx", rapx, 1);
        chk("rst_pix_valid", pix_valid, 0);
        chk("rst_pix_data", pix_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_blk_out", blk_out, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) run_frame(tbl[i]);
        // reset in the middle of FEED, with a capture in flight
        go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0; dct_reading = 1'b1; src_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            src_data = 32'(i + 100);
            @(posedge clk); #1;
        end
        chk("mid_dct_din", dct_din, 32'd139);
        dct_reading = 1'b0; idct_done = 1'b1; idct_dout = 32'h00fe0000;
        @(posedge clk); #1;
        chk("mid_dct_start", dct_start, 1);
        chk("mid_pix_valid", pix_valid, 1);
        chk("mid_pix_data", pix_data, 9'h07f);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("mrst_busy", busy, 0);
        chk("mrst_dct_start", dct_start, 0);
        chk("mrst_pix_valid", pix_valid, 0);
        chk("mrst_frame_done", frame_done, 0);
        chk("mrst_dct_din", dct_din, 0);
        reset = 1'b0; idct_done = 1'b0;
        @(posedge clk); #1;
        run_frame(tbl[0]);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
